// File: rtl/outport_sched.sv
`default_nettype none
// ============================================================================
// Module   : outport_sched
// Purpose  : FIFO-buffered write scheduler for the two-digit output port;
//            issues one-cycle strobes spaced a fixed dwell apart.
// Revision : 1.0  initial release
// ============================================================================
module outport_sched #(
    parameter int DATA_W     = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int DWELL      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_port,
    input  logic [DATA_W-1:0]             req_data,
    input  logic                          flush,
    output logic [DATA_W-1:0]             ind1,
    output logic [DATA_W-1:0]             ind2,
    output logic                          Reg1CR,
    output logic                          Reg2CR,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int DW_W  = $clog2(DWELL);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [DW_W-1:0]     dwell_q, dwell_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic [DATA_W-1:0]   ind1_q, ind1_d;
    logic [DATA_W-1:0]   ind2_q, ind2_d;
    logic                cr1_q, cr1_d;
    logic                cr2_q, cr2_d;
    logic [DATA_W:0]     mem_q [FIFO_DEPTH];
    logic [DATA_W:0]     head;
    logic                push;
    logic                pop;

    assign req_ready  = (count_q != CNT_W'(FIFO_DEPTH));
    assign busy       = (state_q != IDLE) || (count_q != '0);
    assign fifo_count = count_q;
    assign ind1       = ind1_q;
    assign ind2       = ind2_q;
    assign Reg1CR     = cr1_q;
    assign Reg2CR     = cr2_q;

    always_comb begin
        push     = req_valid && req_ready && !flush;
        pop      = (state_q == IDLE) && (count_q != '0);
        head     = mem_q[rd_ptr_q];
        state_d  = state_q;
        dwell_d  = dwell_q;
        ind1_d   = ind1_q;
        ind2_d   = ind2_q;
        cr1_d    = 1'b0;
        cr2_d    = 1'b0;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        // Dwell is loaded with DWELL-2 so HOLD spans DWELL-1 edges and the
        // following IDLE pop lands exactly DWELL edges after this one.
        case (state_q)
            IDLE: begin
                if (pop) begin
                    state_d = HOLD;
                    dwell_d = DW_W'(DWELL - 2);
                    if (head[DATA_W]) begin
                        ind2_d = head[DATA_W-1:0];
                        cr2_d  = 1'b1;
                    end else begin
                        ind1_d = head[DATA_W-1:0];
                        cr1_d  = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (dwell_q == '0) begin
                    state_d = IDLE;
                end else begin
                    dwell_d = dwell_q - DW_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

        // Flush drops everything still queued; a head popped this edge is issued.
        if (flush) begin
            count_d  = '0;
            rd_ptr_d = wr_ptr_q;
        end else begin
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            dwell_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ind1_q   <= '0;
            ind2_q   <= '0;
            cr1_q    <= 1'b0;
            cr2_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            dwell_q  <= dwell_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ind1_q   <= ind1_d;
            ind2_q   <= ind2_d;
            cr1_q    <= cr1_d;
            cr2_q    <= cr2_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {req_port, req_data};
    end

endmodule
`default_nettype wire
